// File: rtl/call_return_stack_if.sv
// call_return_stack_if: request/response handshake between a branch unit and the call/return stack
interface call_return_stack_if #(
    parameter int DATA_W = 18
);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_sel;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] target_in;
    logic [DATA_W-1:0] next_pc;
    logic              next_pc_valid;

    modport master (
        output op_valid, op_sel, pc_in, target_in,
        input  op_ready, next_pc, next_pc_valid
    );

    modport slave (
        input  op_valid, op_sel, pc_in, target_in,
        output op_ready, next_pc, next_pc_valid
    );
endinterface

// File: rtl/call_return_stack.sv
// call_return_stack: return-address stack resolving next PC for call, return and sequential ops
module call_return_stack #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    call_return_stack_if.slave       bus,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf_err,
    output logic                     unf_err,
    input  logic                     err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_sel_q, op_sel_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;
    logic [AW:0]       sp_q, sp_d;
    logic [DATA_W-1:0] next_pc_q, next_pc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] top_val;
    logic              is_call, is_ret, in_exec;
    logic              push, pop, set_ovf, set_unf;

    assign pc_inc  = pc_q + DATA_W'(1);
    assign top_val = mem[AW'(sp_q - 1'b1)];
    assign is_call = op_sel_q == 3'd3;
    assign is_ret  = op_sel_q == 3'd4;
    assign in_exec = state_q == EXEC;
    assign full    = sp_q == DEPTH_CNT;
    assign empty   = sp_q == '0;
    assign push    = in_exec && is_call && !full;
    assign pop     = in_exec && is_ret && !empty;
    assign set_ovf = in_exec && is_call && full;
    assign set_unf = in_exec && is_ret && empty;

    // Next-state: request capture in IDLE, stack update and PC resolution in EXEC
    always_comb begin
        state_d   = state_q;
        op_sel_d  = op_sel_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        sp_d      = push ? sp_q + 1'b1 : pop ? sp_q - 1'b1 : sp_q;
        next_pc_d = next_pc_q;
        ovf_d     = set_ovf | (ovf_q & ~err_clr);
        unf_d     = set_unf | (unf_q & ~err_clr);
        case (state_q)
            IDLE: if (bus.op_valid) begin
                op_sel_d = bus.op_sel;
                pc_d     = bus.pc_in;
                tgt_d    = bus.target_in;
                state_d  = EXEC;
            end
            EXEC: begin
                state_d   = RESP;
                next_pc_d = push ? tgt_q : pop ? top_val : set_unf ? '0 : pc_inc;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        valid_d = state_d == RESP;
    end

    // Control state and registered outputs; reset discards the stack by clearing the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_sel_q  <= '0;
            pc_q      <= '0;
            tgt_q     <= '0;
            sp_q      <= '0;
            next_pc_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_sel_q  <= op_sel_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            sp_q      <= sp_d;
            next_pc_q <= next_pc_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
        end
    end

    // Return-address storage, written on push only and left unreset
    always_ff @(posedge clk) begin
        if (push) mem[sp_q[AW-1:0]] <= pc_inc;
    end

    assign bus.op_ready      = ready_q;
    assign bus.next_pc_valid = valid_q;
    assign bus.next_pc       = next_pc_q;
    assign depth             = sp_q;
    assign ovf_err           = ovf_q;
    assign unf_err           = unf_q;
endmodule
